rf_write_sched: RTL and testbench
=================================

// Module: rf_write_sched
// PURPOSE
//  Write-port scheduler for the 32x32 register file (1 write port, x0 hard-wired 0).
//  Shares the single port between two requesters (0: datapath write-back, 1: debug/host)
//  with valid/ready handshakes and round-robin arbitration.
//  Also runs a clear sequence that zeroes x1..x31 on command.
//  Its rf_we/rf_wa/rf_wd outputs drive the register file's we/wa/wd directly.
// PARAMETERS
//  AW    5   register address width
//  DW    32  register data width
//  NREG  32  number of registers; clear walks 1..NREG-1
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  clr_req      in   1   start clear sequence; sampled only in IDLE
//  clr_busy     out  1   high while state==CLEAR
//  req0_valid   in   1   requester 0 has a write
//  req0_ready   out  1   requester 0 write accepted this cycle
//  req0_addr    in   AW  requester 0 target register
//  req0_data    in   DW  requester 0 write data
//  req1_valid   in   1   requester 1 has a write
//  req1_ready   out  1   requester 1 write accepted this cycle
//  req1_addr    in   AW  requester 1 target register
//  req1_data    in   DW  requester 1 write data
//  rf_we        out  1   register-file write enable, registered
//  rf_wa        out  AW  register-file write address, registered
//  rf_wd        out  DW  register-file write data, registered
// BEHAVIOUR
//  Reset (rst high at posedge):
//   state=IDLE, cnt=0, last_gnt=1, rf_we=0, rf_wa=0, rf_wd=0.
//   clr_busy=0, and both readies are 0 in the reset cycle.
//   Reset mid-CLEAR aborts the sequence; registers already cleared stay cleared.
//  States:
//   IDLE  -> CLEAR when clr_req=1 (cnt<=1)
//   CLEAR -> IDLE at the edge where cnt==NREG-1 is issued
//  IDLE arbitration (combinational readies):
//   clr_req=1 -> both readies 0; clear has priority.
//   One valid -> that requester gets ready=1.
//   Both valid -> grant the requester != last_gnt; on any grant, last_gnt <= granted id.
//   At most one ready high per cycle.
//   A transfer occurs on valid&&ready. The requester holds addr/data stable until ready.
//  Write latency: a transfer in cycle t produces rf_we=1, rf_wa=addr, rf_wd=data in cycle t+1.
//   The register file commits at the end of t+1; the value is readable from cycle t+2.
//   No transfer in t -> rf_we=0 in t+1; rf_wa/rf_wd hold their previous values.
//  Writes to address 0: accepted (ready=1, last_gnt updated) but dropped (rf_we=0 next cycle).
//  CLEAR:
//   Each cycle register rf_we=1, rf_wa=cnt, rf_wd=0; then cnt<=cnt+1.
//   Lasts exactly NREG-1=31 cycles. clr_busy=1 and readies=0 throughout.
//   clr_req is ignored while in CLEAR.
//  Ordering:
//   The first request after CLEAR is accepted in the first IDLE cycle.
//   Its write lands the cycle after the last clear write, with no port collision.
//  Same-address requests from both requesters are serialised: the later-granted write wins.
//  Widths: cnt is AW bits; the compare to NREG-1 is done at AW bits; no wrap past NREG-1.
// STRUCTURE
//  Shared header rf_defs.vh:
//   AW/DW/NREG defaults, state encodings ST_IDLE=1'b0 / ST_CLEAR=1'b1, requester ids.
//  Sub-module rr_arb2:
//   2-way round-robin arbiter (req[1:0], last_gnt -> gnt[1:0]), purely combinational.
//  Top level holds the FSM, the clear counter, last_gnt and the output registers.
// TESTING
//  1) rst 2 cycles, then idle: rf_we=0, readies=0 with no valid, clr_busy=0.
//  2) req0 valid addr=5 data=0x1234 at t:
//     req0_ready=1 at t; t+1 rf_we=1, wa=5, wd=0x1234; rd(5)=0x1234 at t+2.
//  3) Both valid for 4 cycles (addr 3 and 4) after reset:
//     grants in order 0,1,0,1 (req0 first); rf_wa sequence 3,4,3,4.
//  4) req1 addr=0 data=0xFFFF:
//     ready=1, next cycle rf_we=0; rd(0) stays 0; last_gnt becomes 1.
//  5) clr_req pulse:
//     clr_busy high 31 cycles; rf_we=1 with wa 1..31, wd=0; req0_valid held high meanwhile,
//     ready=0 until the first IDLE cycle; all rd(1..31)=0 afterwards.
//  6) rst asserted on the 10th CLEAR cycle: next cycle IDLE, clr_busy=0, rf_we=0;
//     x1..x9 zero, x10..x31 keep their initial values.

Source files
------------

// File: rtl/rf_write_sched_pkg.sv
// Shared definitions for the register-file write-port scheduler:
// default geometry, FSM state encoding and requester ids.
package rf_write_sched_pkg;

    localparam int unsigned RF_AW   = 5;
    localparam int unsigned RF_DW   = 32;
    localparam int unsigned RF_NREG = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Requester ids as stored in last_gnt
    localparam logic REQ_DP  = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/rf_write_sched_arb.sv
// Two-way round-robin arbiter: with both requesting, the requester that
// was not granted last wins. Purely combinational.
module rf_write_sched_arb
    import rf_write_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt_c
);

    always_comb begin
        gnt_c = 2'b00;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = (last_gnt == REQ_DBG) ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_write_sched.sv
// Write-port scheduler for the 32x32 register file: shares the single write
// port between two requesters and runs a clear sequence over x1..x(NREG-1).
module rf_write_sched
    import rf_write_sched_pkg::*;
#(
    parameter int unsigned AW   = RF_AW,
    parameter int unsigned DW   = RF_DW,
    parameter int unsigned NREG = RF_NREG
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd
);

    state_e        state;
    logic [AW-1:0] cnt;
    logic          last_gnt;

    logic [1:0]    gnt_c;
    logic          arb_en_c;
    logic          xfer_c;
    logic          xfer_id_c;
    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] sel_data_c;
    logic          cnt_last_c;

    rf_write_sched_arb u_arb (
        .req      ({req1_valid, req0_valid}),
        .last_gnt (last_gnt),
        .gnt_c    (gnt_c)
    );

    // Port is offered only in IDLE; a pending clear request outranks both requesters
    assign arb_en_c   = !rst && (state == ST_IDLE) && !clr_req;
    assign req0_ready = arb_en_c && gnt_c[0];
    assign req1_ready = arb_en_c && gnt_c[1];

    assign xfer_c     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign xfer_id_c  = req1_ready ? REQ_DBG : REQ_DP;
    assign sel_addr_c = req1_ready ? req1_addr : req0_addr;
    assign sel_data_c = req1_ready ? req1_data : req0_data;

    assign cnt_last_c = (cnt == AW'(NREG - 1));
    assign clr_busy   = (state == ST_CLEAR);

    // FSM, clear counter, round-robin history and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last_gnt <= REQ_DBG;
            rf_we    <= 1'b0;
            rf_wa    <= '0;
            rf_wd    <= '0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        cnt   <= AW'(1);
                    end else if (xfer_c) begin
                        last_gnt <= xfer_id_c;
                        // x0 is hard-wired: accept the transfer but suppress the write
                        if (sel_addr_c != '0) begin
                            rf_we <= 1'b1;
                            rf_wa <= sel_addr_c;
                            rf_wd <= sel_data_c;
                        end
                    end
                end
                ST_CLEAR: begin
                    rf_we <= 1'b1;
                    rf_wa <= cnt;
                    rf_wd <= '0;
                    if (cnt_last_c) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_sched.sv
// Self-checking bench for rf_write_sched: directed scenarios plus a randomized
// run checked against a transaction-level model and a register-file image.
module tb_rf_write_sched;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;

    logic          clk;
    logic          rst;
    logic          clr_req;
    logic          clr_busy;
    logic          req0_valid, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    logic [DW-1:0] rf_mem [NREG];
    logic          rf_init;
    int            n_tests;
    int            n_fail;

    rf_write_sched dut (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Register file driven by the scheduler's write port
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < NREG; i++)
                rf_mem[i] <= (i == 0) ? '0 : init_val(i);
        end else if (rf_we) begin
            rf_mem[rf_wa] <= rf_wd;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        next_cycle();
        rf_init = 1'b0;
        @(negedge clk);
        n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_we); end
        n_tests++; if (rf_wa !== 5'd0 || rf_wd !== 32'd0) begin n_fail++; $display("FAIL reset_wa_wd: got %0d/%h want 0/0", rf_wa, rf_wd); end
        n_tests++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", clr_busy); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0_c2: got %b want 0", req0_ready); end
        next_cycle();
        rst = 1'b0; req0_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL idle_readies: got %b%b want 00", req1_ready, req0_ready); end
        n_tests++; if (rf_we !== 1'b0 || clr_busy !== 1'b0) begin n_fail++; $display("FAIL idle_we_busy: got %b/%b want 0/0", rf_we, clr_busy); end
        next_cycle();
    endtask

    task automatic test_single_write();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h1234;
        @(negedge clk);
        n_tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready: got %b%b want 01", req1_ready, req0_ready); end
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'h1234) begin n_fail++; $display("FAIL single_write: got we=%b wa=%0d wd=%h want 1/5/1234", rf_we, rf_wa, rf_wd); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (rf_mem[5] !== 32'h1234) begin n_fail++; $display("FAIL single_rd5: got %h want 1234", rf_mem[5]); end
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_we_drop: got %b want 0", rf_we); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_wa [4];
        logic [DW-1:0] exp_wd [4];
        logic          e0;
        exp_wa = '{5'd3, 5'd4, 5'd3, 5'd4};
        exp_wd = '{32'h3000, 32'h4000, 32'h3001, 32'h4001};
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h3000;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h4000;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(negedge clk);
            e0 = ((i % 2) == 0);
            if (i < 4) begin
                n_tests++; if (req0_ready !== e0 || req1_ready !== !e0) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b%b want %b%b", i, req1_ready, req0_ready, !e0, e0); end
            end
            if (i > 0) begin
                n_tests++; if (rf_we !== 1'b1 || rf_wa !== exp_wa[i-1] || rf_wd !== exp_wd[i-1]) begin n_fail++; $display("FAIL rr_write[%0d]: got we=%b wa=%0d wd=%h want 1/%0d/%h", i-1, rf_we, rf_wa, rf_wd, exp_wa[i-1], exp_wd[i-1]); end
            end
            next_cycle();
            if (i == 0) req0_data = 32'h3001;
            if (i == 1) req1_data = 32'h4001;
        end
    endtask

    task automatic test_addr0();
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
        @(negedge clk);
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL a0_pre_grant: got %b want 1", req0_ready); end
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF;
        @(negedge clk);
        n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL a0_ready: got %b want 1", req1_ready); end
        next_cycle();
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h88;
        @(negedge clk);
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL a0_we: got %b want 0", rf_we); end
        n_tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL a0_last_gnt: got %b%b want 01", req1_ready, req0_ready); end
        next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (rf_mem[0] !== 32'd0) begin n_fail++; $display("FAIL a0_rd0: got %h want 0", rf_mem[0]); end
        n_tests++; if (rf_we !== 1'b1 || rf_wa !== 5'd7) begin n_fail++; $display("FAIL a0_follow: got we=%b wa=%0d want 1/7", rf_we, rf_wa); end
        next_cycle();
    endtask

    task automatic test_reset_mid_clear();
        clr_req = 1'b1;
        next_cycle();
        clr_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) rst = 1'b1;
            @(negedge clk);
            n_tests++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL rmc_busy[%0d]: got %b want 1", k, clr_busy); end
            if (k >= 2) begin
                n_tests++; if (rf_we !== 1'b1 || rf_wa !== AW'(k - 1)) begin n_fail++; $display("FAIL rmc_wa[%0d]: got we=%b wa=%0d want 1/%0d", k, rf_we, rf_wa, k - 1); end
            end
            next_cycle();
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (clr_busy !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL rmc_abort: got busy=%b we=%b want 0/0", clr_busy, rf_we); end
        next_cycle();
        @(negedge clk);
        for (int a = 1; a < NREG; a++) begin
            n_tests++;
            if (rf_mem[a] !== ((a < 10) ? 32'd0 : init_val(a))) begin
                n_fail++; $display("FAIL rmc_rd[%0d]: got %h want %h", a, rf_mem[a], (a < 10) ? 32'd0 : init_val(a));
            end
        end
        next_cycle();
    endtask

    task automatic test_clear();
        clr_req = 1'b1; req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hABCD;
        @(negedge clk);
        n_tests++; if (req0_ready !== 1'b0 || clr_busy !== 1'b0) begin n_fail++; $display("FAIL clr_start: got ready=%b busy=%b want 0/0", req0_ready, clr_busy); end
        next_cycle();
        for (int k = 1; k <= 31; k++) begin
            clr_req = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            n_tests++; if (clr_busy !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL clr_busy[%0d]: got busy=%b ready=%b want 1/0", k, clr_busy, req0_ready); end
            if (k >= 2) begin
                n_tests++; if (rf_we !== 1'b1 || rf_wa !== AW'(k - 1) || rf_wd !== 32'd0) begin n_fail++; $display("FAIL clr_write[%0d]: got we=%b wa=%0d wd=%h want 1/%0d/0", k, rf_we, rf_wa, rf_wd, k - 1); end
            end
            next_cycle();
        end
        clr_req = 1'b0;
        @(negedge clk);
        n_tests++; if (clr_busy !== 1'b0 || req0_ready !== 1'b1) begin n_fail++; $display("FAIL clr_exit: got busy=%b ready=%b want 0/1", clr_busy, req0_ready); end
        n_tests++; if (rf_we !== 1'b1 || rf_wa !== 5'd31) begin n_fail++; $display("FAIL clr_last: got we=%b wa=%0d want 1/31", rf_we, rf_wa); end
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (rf_we !== 1'b1 || rf_wa !== 5'd9 || rf_wd !== 32'hABCD) begin n_fail++; $display("FAIL clr_after: got we=%b wa=%0d wd=%h want 1/9/abcd", rf_we, rf_wa, rf_wd); end
        next_cycle();
        @(negedge clk);
        for (int a = 1; a < NREG; a++) begin
            n_tests++;
            if (rf_mem[a] !== ((a == 9) ? 32'hABCD : 32'd0)) begin
                n_fail++; $display("FAIL clr_rd[%0d]: got %h want %h", a, rf_mem[a], (a == 9) ? 32'hABCD : 32'd0);
            end
        end
        next_cycle();
    endtask

    // Random traffic against a transaction-level model of the port
    task automatic test_random();
        localparam int N = 600;
        int            m_left = 0;
        int            m_next = 0;
        logic          m_last = 1'b1;
        logic          m_we = 1'b0;
        logic [AW-1:0] m_wa = '0;
        logic [DW-1:0] m_wd = '0;
        logic [DW-1:0] gold [NREG];
        logic          er0, er1, h0, h1;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            quiet;
        h0 = 1'b0; h1 = 1'b0;
        for (int i = 0; i < NREG; i++) gold[i] = '0;
        for (int cyc = 0; cyc < N; cyc++) begin
            quiet   = (cyc >= N - 80);
            rst     = (cyc == 0) || (cyc > 60 && !quiet && $urandom_range(0, 149) == 0);
            clr_req = (cyc == 1) || (cyc > 60 && !quiet && $urandom_range(0, 49) == 0);
            if (!h0) begin
                req0_valid = (cyc < N - 40) && ($urandom_range(0, 2) != 0);
                req0_addr  = AW'($urandom_range(0, 31));
                req0_data  = $urandom();
            end
            if (!h1) begin
                req1_valid = (cyc < N - 40) && ($urandom_range(0, 2) != 0);
                req1_addr  = ($urandom_range(0, 3) == 0) ? req0_addr : AW'($urandom_range(0, 31));
                req1_data  = $urandom();
            end
            @(negedge clk);
            if (rst || m_left > 0 || clr_req) begin er0 = 1'b0; er1 = 1'b0; end
            else if (req0_valid && req1_valid) begin er0 = m_last; er1 = !m_last; end
            else begin er0 = req0_valid; er1 = req1_valid; end
            n_tests++; if (req0_ready !== er0 || req1_ready !== er1) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b%b want %b%b", cyc, req1_ready, req0_ready, er1, er0); end
            if (cyc > 0) begin
                n_tests++; if (clr_busy !== (m_left > 0)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, clr_busy, m_left > 0); end
                n_tests++; if (rf_we !== m_we) begin n_fail++; $display("FAIL rnd_we@%0d: got %b want %b", cyc, rf_we, m_we); end
                if (m_we) begin
                    n_tests++; if (rf_wa !== m_wa || rf_wd !== m_wd) begin n_fail++; $display("FAIL rnd_wa_wd@%0d: got %0d/%h want %0d/%h", cyc, rf_wa, rf_wd, m_wa, m_wd); end
                end
            end
            if (rst) begin
                m_left = 0; m_last = 1'b1; m_we = 1'b0; m_wa = '0; m_wd = '0;
            end else if (m_left > 0) begin
                m_we = 1'b1; m_wa = AW'(m_next); m_wd = '0; gold[m_next] = '0;
                m_next++; m_left--;
            end else if (clr_req) begin
                m_left = NREG - 1; m_next = 1; m_we = 1'b0;
            end else if (er0 || er1) begin
                m_last = er1;
                addr   = er1 ? req1_addr : req0_addr;
                data   = er1 ? req1_data : req0_data;
                m_we   = (addr != '0);
                if (m_we) begin m_wa = addr; m_wd = data; gold[addr] = data; end
            end else begin
                m_we = 1'b0;
            end
            h0 = req0_valid && !er0;
            h1 = req1_valid && !er1;
            next_cycle();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0; clr_req = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        for (int a = 1; a < NREG; a++) begin
            n_tests++; if (rf_mem[a] !== gold[a]) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %h want %h", a, rf_mem[a], gold[a]); end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rf_init = 1'b1; rst = 1'b1; clr_req = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_addr0();
        test_reset_mid_clear();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
